// File: rtl/comperator_acc_pkg.sv
// comperator_acc_pkg: shared state encoding and default widths for the frame accumulator
package comperator_acc_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, HOLD = 2'd2} state_t;
    localparam int def_data_wd = 16;
    localparam int def_idx_wd = 4;
    localparam int def_hi = 15;
    localparam int def_lo = 0;
    localparam int def_pos_wd = 8;
endpackage

// File: rtl/comperator_2.sv
// comperator_2: two-input unsigned extreme select on data[hi:lo]; equal fields resolve to d1
module comperator_2
    import comperator_acc_pkg::*;
#(
    parameter int data_wd = def_data_wd,
    parameter int idx_wd = def_idx_wd,
    parameter int hi = def_hi,
    parameter int lo = def_lo
) (
    input  logic [data_wd-1:0] d0_dat,
    input  logic [idx_wd-1:0]  d0_idx,
    input  logic               d0_dv,
    input  logic [data_wd-1:0] d1_dat,
    input  logic [idx_wd-1:0]  d1_idx,
    input  logic               d1_dv,
    input  logic               great_n_small,
    output logic [data_wd-1:0] c_dat,
    output logic [idx_wd-1:0]  c_idx,
    output logic               c_sel
);
    logic [hi-lo:0] f0, f1;
    always_comb begin
        f0 = d0_dat[hi:lo];
        f1 = d1_dat[hi:lo];
        c_sel = d1_dv & (~d0_dv | (great_n_small ? f1 >= f0 : f1 <= f0));
        c_dat = c_sel ? d1_dat : d0_dat;
        c_idx = c_sel ? d1_idx : d0_idx;
    end
endmodule

// File: rtl/comperator_acc.sv
// comperator_acc: per-frame running min/max of comparator results, presented on a valid/ready port
module comperator_acc
    import comperator_acc_pkg::*;
#(
    parameter int data_wd = def_data_wd,
    parameter int idx_wd = def_idx_wd,
    parameter int hi = def_hi,
    parameter int lo = def_lo,
    parameter int pos_wd = def_pos_wd
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [data_wd-1:0] in_dat,
    input  logic [idx_wd-1:0]  in_idx,
    input  logic               in_dv,
    input  logic               in_last,
    input  logic               great_n_small,
    output logic               in_rdy,
    output logic [data_wd-1:0] res_dat,
    output logic [idx_wd-1:0]  res_idx,
    output logic [pos_wd-1:0]  res_pos,
    output logic               res_ovf,
    output logic               res_vd,
    input  logic               res_rdy
);
    state_t state;
    logic mode, ovf, first, acc, rep, c_sel;
    logic [data_wd-1:0] best_dat, c_dat, nx_dat;
    logic [idx_wd-1:0] best_idx, c_idx, nx_idx;
    logic [pos_wd-1:0] best_pos, cnt, nx_pos;

    comperator_2 #(.data_wd(data_wd), .idx_wd(idx_wd), .hi(hi), .lo(lo)) u_cmp (
        .d0_dat(best_dat), .d0_idx(best_idx), .d0_dv(1'b1),
        .d1_dat(in_dat), .d1_idx(in_idx), .d1_dv(1'b1),
        .great_n_small(mode), .c_dat(c_dat), .c_idx(c_idx), .c_sel(c_sel)
    );

    // the comparator favours d1 on ties, so equal fields are masked out to keep the earlier sample
    always_comb begin
        in_rdy = (state != HOLD) | res_rdy;
        acc = in_dv & in_rdy;
        first = state != ACC;
        rep = c_sel & (in_dat[hi:lo] != best_dat[hi:lo]);
        nx_dat = first ? in_dat : rep ? c_dat : best_dat;
        nx_idx = first ? in_idx : rep ? c_idx : best_idx;
        nx_pos = first ? '0 : rep ? cnt : best_pos;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            mode <= 1'b0;
            ovf <= 1'b0;
            cnt <= '0;
            best_dat <= '0;
            best_idx <= '0;
            best_pos <= '0;
            res_dat <= '0;
            res_idx <= '0;
            res_pos <= '0;
            res_ovf <= 1'b0;
            res_vd <= 1'b0;
        end else if (acc) begin
            best_dat <= nx_dat;
            best_idx <= nx_idx;
            best_pos <= nx_pos;
            cnt <= first ? pos_wd'(1) : cnt + 1'b1;
            ovf <= ~first & (ovf | (&cnt));
            if (first) mode <= great_n_small;
            state <= in_last ? HOLD : ACC;
            res_vd <= in_last;
            if (in_last) begin
                res_dat <= nx_dat;
                res_idx <= nx_idx;
                res_pos <= nx_pos;
                res_ovf <= ~first & ovf;
            end
        end else if (state == HOLD && res_rdy) begin
            state <= IDLE;
            res_vd <= 1'b0;
        end
    end
endmodule
